// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the instruction-fetch port, the load/store
// port, the shared memory bus and the arbiter that multiplexes them.
interface mem_port_arbiter_if #(
    parameter int WIDTH = 32
);
    localparam int BEW = WIDTH / 8;

    // I-port (instruction fetch, read only)
    logic             i_req_in;
    logic [WIDTH-1:0] i_addr_in;
    logic [WIDTH-1:0] i_rdata_out;
    logic             i_valid_out;
    logic             i_err_out;
    logic             i_stall_out;

    // D-port (load/store)
    logic             d_req_in;
    logic             d_we_in;
    logic [BEW-1:0]   d_be_in;
    logic [WIDTH-1:0] d_addr_in;
    logic [WIDTH-1:0] d_wdata_in;
    logic [WIDTH-1:0] d_rdata_out;
    logic             d_valid_out;
    logic             d_err_out;
    logic             d_stall_out;

    // Memory bus (req/ack)
    logic             mem_req_out;
    logic             mem_we_out;
    logic [BEW-1:0]   mem_be_out;
    logic [WIDTH-1:0] mem_addr_out;
    logic [WIDTH-1:0] mem_wdata_out;
    logic [WIDTH-1:0] mem_rdata_in;
    logic             mem_ack_in;

    // Arbiter side
    modport slave (
        input  i_req_in, i_addr_in,
        output i_rdata_out, i_valid_out, i_err_out, i_stall_out,
        input  d_req_in, d_we_in, d_be_in, d_addr_in, d_wdata_in,
        output d_rdata_out, d_valid_out, d_err_out, d_stall_out,
        output mem_req_out, mem_we_out, mem_be_out, mem_addr_out, mem_wdata_out,
        input  mem_rdata_in, mem_ack_in
    );

    // Requester / memory side
    modport master (
        output i_req_in, i_addr_in,
        input  i_rdata_out, i_valid_out, i_err_out, i_stall_out,
        output d_req_in, d_we_in, d_be_in, d_addr_in, d_wdata_in,
        input  d_rdata_out, d_valid_out, d_err_out, d_stall_out,
        input  mem_req_out, mem_we_out, mem_be_out, mem_addr_out, mem_wdata_out,
        output mem_rdata_in, mem_ack_in
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between the instruction-fetch port
// and the load/store port. One transaction in flight at a time; D wins ties
// unless the I-port has lost STARVE_MAX arbitrations in a row. A watchdog
// aborts a transaction that waits TIMEOUT cycles without an ack.
module mem_port_arbiter #(
    parameter int WIDTH      = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input logic              clk_in,
    input logic              rst_in,
    mem_port_arbiter_if.slave bus
);
    localparam int BEW = WIDTH / 8;
    localparam int SW  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [TW-1:0] TMO_LAST   = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic [TW-1:0]    tmo_q, tmo_d;

    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [BEW-1:0]   mem_be_q, mem_be_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic [WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic             i_valid_q, i_valid_d;
    logic             i_err_q, i_err_d;
    logic [WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic             d_valid_q, d_valid_d;
    logic             d_err_q, d_err_d;

    logic             finish;
    logic             acked;

    // Next-state: arbitration from IDLE, completion/abort from the busy states
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        tmo_d       = tmo_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        i_valid_d   = 1'b0;
        i_err_d     = 1'b0;
        d_rdata_d   = d_rdata_q;
        d_valid_d   = 1'b0;
        d_err_d     = 1'b0;
        acked       = bus.mem_ack_in;
        finish      = bus.mem_ack_in || ((TIMEOUT != 0) && (tmo_q == TMO_LAST));

        case (state_q)
            IDLE: begin
                // A request still held during its own valid pulse is stale;
                // arbitration resumes one cycle later.
                if (!(i_valid_q || d_valid_q)) begin
                    if (bus.d_req_in && !(bus.i_req_in && (starve_q == STARVE_LIM))) begin
                        state_d     = BUSY_D;
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.d_we_in;
                        mem_be_d    = bus.d_be_in;
                        mem_addr_d  = bus.d_addr_in;
                        mem_wdata_d = bus.d_wdata_in;
                        tmo_d       = '0;
                        if (bus.i_req_in) begin
                            starve_d = starve_q + SW'(1);
                        end
                    end else if (bus.i_req_in) begin
                        state_d     = BUSY_I;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_be_d    = '1;
                        mem_addr_d  = bus.i_addr_in;
                        mem_wdata_d = '0;
                        tmo_d       = '0;
                        starve_d    = '0;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (finish) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (state_q == BUSY_I) begin
                        i_valid_d = 1'b1;
                        i_err_d   = !acked;
                        i_rdata_d = acked ? bus.mem_rdata_in : '0;
                    end else begin
                        d_valid_d = 1'b1;
                        d_err_d   = !acked;
                        d_rdata_d = (acked && !mem_we_q) ? bus.mem_rdata_in : '0;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset also aborts any transaction in flight
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            tmo_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            i_valid_q   <= 1'b0;
            i_err_q     <= 1'b0;
            d_rdata_q   <= '0;
            d_valid_q   <= 1'b0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            tmo_q       <= tmo_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            i_valid_q   <= i_valid_d;
            i_err_q     <= i_err_d;
            d_rdata_q   <= d_rdata_d;
            d_valid_q   <= d_valid_d;
            d_err_q     <= d_err_d;
        end
    end

    assign bus.mem_req_out   = mem_req_q;
    assign bus.mem_we_out    = mem_we_q;
    assign bus.mem_be_out    = mem_be_q;
    assign bus.mem_addr_out  = mem_addr_q;
    assign bus.mem_wdata_out = mem_wdata_q;
    assign bus.i_rdata_out   = i_rdata_q;
    assign bus.i_valid_out   = i_valid_q;
    assign bus.i_err_out     = i_err_q;
    assign bus.d_rdata_out   = d_rdata_q;
    assign bus.d_valid_out   = d_valid_q;
    assign bus.d_err_out     = d_err_q;

    // Stalls drop in the valid cycle so the pipeline advances exactly once
    assign bus.i_stall_out = bus.i_req_in & ~i_valid_q;
    assign bus.d_stall_out = bus.d_req_in & ~d_valid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table-driven vectors, directed multi-cycle
// sequences, then random traffic against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int W    = 32;
    localparam int SMAX = 4;
    localparam int TMO  = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.WIDTH(W)) bus ();

    mem_port_arbiter #(.WIDTH(W), .STARVE_MAX(SMAX), .TIMEOUT(TMO)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.i_req_in     = 1'b0;
        bus.d_req_in     = 1'b0;
        bus.d_we_in      = 1'b0;
        bus.mem_ack_in   = 1'b0;
        bus.mem_rdata_in = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- table-driven vectors ----------------
    typedef struct packed {
        logic        rst, ireq, dreq, dwe, ack;
        logic [31:0] rdata;
        logic        mreq, mwe;
        logic [3:0]  mbe;
        logic [31:0] maddr;
        logic        iv, ie;
        logic [31:0] ird;
        logic        dv, de;
        logic [31:0] drd;
    } vec_t;

    vec_t tbl [16];

    // ---------------- reference model ----------------
    int   m_owner;   // 0 none, 1 I, 2 D
    int   m_waited;
    int   m_lost;
    bit   m_cool;
    logic e_mreq, e_mwe, e_iv, e_ie, e_dv, e_de;
    logic [3:0]  e_mbe;
    logic [31:0] e_maddr, e_mwdata, e_ird, e_drd;

    task automatic model_finish(input bit ok);
        if (m_owner == 1) begin
            e_iv = 1'b1; e_ie = !ok; e_ird = ok ? bus.mem_rdata_in : 32'h0;
        end else begin
            e_dv = 1'b1; e_de = !ok; e_drd = (ok && !e_mwe) ? bus.mem_rdata_in : 32'h0;
        end
        e_mreq  = 1'b0;
        m_owner = 0;
        m_cool  = 1'b1;
    endtask

    task automatic model_step();
        if (rst) begin
            m_owner = 0; m_waited = 0; m_lost = 0; m_cool = 1'b0;
            e_mreq = 0; e_mwe = 0; e_mbe = 0; e_maddr = 0; e_mwdata = 0;
            e_iv = 0; e_ie = 0; e_ird = 0; e_dv = 0; e_de = 0; e_drd = 0;
            return;
        end
        e_iv = 1'b0; e_ie = 1'b0; e_dv = 1'b0; e_de = 1'b0;
        if (m_owner == 0) begin
            if (!m_cool) begin
                if (bus.d_req_in && (!bus.i_req_in || m_lost < SMAX)) begin
                    m_owner = 2; m_waited = 0; e_mreq = 1'b1;
                    e_mwe = bus.d_we_in; e_mbe = bus.d_be_in;
                    e_maddr = bus.d_addr_in; e_mwdata = bus.d_wdata_in;
                    if (bus.i_req_in) m_lost++;
                end else if (bus.i_req_in) begin
                    m_owner = 1; m_waited = 0; e_mreq = 1'b1;
                    e_mwe = 1'b0; e_mbe = 4'hF; e_maddr = bus.i_addr_in;
                    m_lost = 0;
                end
            end
            m_cool = 1'b0;
        end else if (bus.mem_ack_in) begin
            model_finish(1'b1);
        end else begin
            m_waited++;
            if (TMO > 0 && m_waited == TMO) model_finish(1'b0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int   n, gcount, pulses;
        logic prev;
        bit   deaf;
        logic prev_req;

        drive_idle();
        bus.i_addr_in  = 32'h40;
        bus.d_addr_in  = 32'h80;
        bus.d_be_in    = 4'b0011;
        bus.d_wdata_in = 32'hDEADBEEF;

        //          rst ireq dreq dwe ack rdata          mreq mwe mbe   maddr   iv ie ird            dv de drd
        tbl[0]  = '{1, 0, 0, 0, 0, 32'h0,         0, 0, 4'h0, 32'h0,  0, 0, 32'h0,         0, 0, 32'h0};
        tbl[1]  = '{0, 0, 0, 0, 0, 32'h0,         0, 0, 4'h0, 32'h0,  0, 0, 32'h0,         0, 0, 32'h0};
        tbl[2]  = '{0, 0, 0, 0, 1, 32'h11111111,  0, 0, 4'h0, 32'h0,  0, 0, 32'h0,         0, 0, 32'h0};
        tbl[3]  = '{0, 1, 0, 0, 0, 32'h0,         1, 0, 4'hF, 32'h40, 0, 0, 32'h0,         0, 0, 32'h0};
        tbl[4]  = '{0, 1, 0, 0, 0, 32'h0,         1, 0, 4'hF, 32'h40, 0, 0, 32'h0,         0, 0, 32'h0};
        tbl[5]  = '{0, 1, 0, 0, 1, 32'h00500093,  0, 0, 4'h0, 32'h0,  1, 0, 32'h00500093,  0, 0, 32'h0};
        tbl[6]  = '{0, 0, 0, 0, 0, 32'h0,         0, 0, 4'h0, 32'h0,  0, 0, 32'h0,         0, 0, 32'h0};
        tbl[7]  = '{0, 1, 1, 1, 0, 32'h0,         1, 1, 4'h3, 32'h80, 0, 0, 32'h0,         0, 0, 32'h0};
        tbl[8]  = '{0, 1, 1, 1, 1, 32'h12345678,  0, 0, 4'h0, 32'h0,  0, 0, 32'h0,         1, 0, 32'h0};
        tbl[9]  = '{0, 1, 0, 0, 0, 32'h0,         0, 0, 4'h0, 32'h0,  0, 0, 32'h0,         0, 0, 32'h0};
        tbl[10] = '{0, 1, 0, 0, 0, 32'h0,         1, 0, 4'hF, 32'h40, 0, 0, 32'h0,         0, 0, 32'h0};
        tbl[11] = '{0, 1, 0, 0, 1, 32'hCAFEF00D,  0, 0, 4'h0, 32'h0,  1, 0, 32'hCAFEF00D,  0, 0, 32'h0};
        tbl[12] = '{0, 0, 0, 0, 0, 32'h0,         0, 0, 4'h0, 32'h0,  0, 0, 32'h0,         0, 0, 32'h0};
        tbl[13] = '{0, 0, 1, 0, 0, 32'h0,         1, 0, 4'h3, 32'h80, 0, 0, 32'h0,         0, 0, 32'h0};
        tbl[14] = '{0, 0, 1, 0, 1, 32'hA5A5A5A5,  0, 0, 4'h0, 32'h0,  0, 0, 32'h0,         1, 0, 32'hA5A5A5A5};
        tbl[15] = '{0, 0, 0, 0, 0, 32'h0,         0, 0, 4'h0, 32'h0,  0, 0, 32'h0,         0, 0, 32'h0};

        for (int k = 0; k < 16; k++) begin
            vec_t t;
            t = tbl[k];
            rst              = t.rst;
            bus.i_req_in     = t.ireq;
            bus.d_req_in     = t.dreq;
            bus.d_we_in      = t.dwe;
            bus.mem_ack_in   = t.ack;
            bus.mem_rdata_in = t.rdata;
            tick();
            check($sformatf("tbl[%0d] mem_req", k), bus.mem_req_out, t.mreq);
            if (t.mreq) begin
                check($sformatf("tbl[%0d] mem_we", k), bus.mem_we_out, t.mwe);
                check($sformatf("tbl[%0d] mem_be", k), bus.mem_be_out, t.mbe);
                check($sformatf("tbl[%0d] mem_addr", k), bus.mem_addr_out, t.maddr);
                if (t.mwe) check($sformatf("tbl[%0d] mem_wdata", k), bus.mem_wdata_out, 32'hDEADBEEF);
            end
            if (t.rst) begin
                check("reset mem_addr", bus.mem_addr_out, 0);
                check("reset mem_wdata", bus.mem_wdata_out, 0);
                check("reset mem_be", bus.mem_be_out, 0);
                check("reset mem_we", bus.mem_we_out, 0);
                check("reset i_rdata", bus.i_rdata_out, 0);
                check("reset d_rdata", bus.d_rdata_out, 0);
                check("reset i_err", bus.i_err_out, 0);
                check("reset d_err", bus.d_err_out, 0);
            end
            check($sformatf("tbl[%0d] i_valid", k), bus.i_valid_out, t.iv);
            check($sformatf("tbl[%0d] d_valid", k), bus.d_valid_out, t.dv);
            if (t.iv) begin
                check($sformatf("tbl[%0d] i_err", k), bus.i_err_out, t.ie);
                check($sformatf("tbl[%0d] i_rdata", k), bus.i_rdata_out, t.ird);
            end
            if (t.dv) begin
                check($sformatf("tbl[%0d] d_err", k), bus.d_err_out, t.de);
                check($sformatf("tbl[%0d] d_rdata", k), bus.d_rdata_out, t.drd);
            end
            check($sformatf("tbl[%0d] i_stall", k), bus.i_stall_out, t.ireq & ~t.iv);
            check($sformatf("tbl[%0d] d_stall", k), bus.d_stall_out, t.dreq & ~t.dv);
        end
        rst = 1'b0;

        // ---------------- reset during BUSY_D ----------------
        do_reset();
        bus.d_req_in = 1'b1; bus.d_we_in = 1'b0;
        tick();
        check("rstbusy granted", bus.mem_req_out, 1);
        rst = 1'b1; bus.mem_ack_in = 1'b1; bus.mem_rdata_in = 32'h77777777;
        tick();
        check("rstbusy mem_req", bus.mem_req_out, 0);
        check("rstbusy d_valid", bus.d_valid_out, 0);
        rst = 1'b0; bus.mem_ack_in = 1'b0; bus.d_req_in = 1'b0;
        tick();
        check("rstbusy after d_valid", bus.d_valid_out, 0);
        check("rstbusy after mem_req", bus.mem_req_out, 0);

        // ---------------- starvation guard ----------------
        do_reset();
        bus.i_req_in = 1'b1; bus.d_req_in = 1'b1; bus.d_we_in = 1'b1;
        gcount = 0; prev = 1'b0;
        for (int c = 0; c < 60 && gcount < 10; c++) begin
            bus.mem_ack_in = bus.mem_req_out;
            tick();
            if (bus.mem_req_out && !prev) begin
                check($sformatf("starve grant%0d is_I", gcount),
                      bus.mem_addr_out == 32'h40, (gcount % 5) == 4);
                gcount++;
            end
            prev = bus.mem_req_out;
        end
        check("starve grant count", gcount, 10);
        drive_idle();
        tick();
        tick();

        // ---------------- watchdog timeout ----------------
        do_reset();
        bus.i_req_in = 1'b1;
        tick();
        check("tmo grant", bus.mem_req_out, 1);
        n = 0;
        while (bus.mem_req_out && n < 40) begin
            n++;
            tick();
        end
        check("tmo busy cycles", n, TMO);
        check("tmo i_valid", bus.i_valid_out, 1);
        check("tmo i_err", bus.i_err_out, 1);
        check("tmo i_rdata", bus.i_rdata_out, 0);
        check("tmo i_stall", bus.i_stall_out, 0);
        bus.i_req_in = 1'b0;
        tick();
        check("tmo pulse width", bus.i_valid_out, 0);
        bus.d_req_in = 1'b1; bus.d_we_in = 1'b0;
        tick();
        check("tmo idle regrant", bus.mem_req_out, 1);
        check("tmo idle regrant addr", bus.mem_addr_out, 32'h80);
        bus.mem_ack_in = 1'b1; bus.mem_rdata_in = 32'h0BADF00D;
        tick();
        check("tmo next d_valid", bus.d_valid_out, 1);
        check("tmo next d_err", bus.d_err_out, 0);
        check("tmo next d_rdata", bus.d_rdata_out, 32'h0BADF00D);
        drive_idle();
        tick();

        // ---------------- spurious ack + dropped request ----------------
        do_reset();
        bus.mem_ack_in = 1'b1; bus.mem_rdata_in = 32'h55555555;
        tick();
        tick();
        check("spurious mem_req", bus.mem_req_out, 0);
        check("spurious i_valid", bus.i_valid_out, 0);
        check("spurious d_valid", bus.d_valid_out, 0);
        bus.mem_ack_in = 1'b0; bus.i_req_in = 1'b1; bus.i_addr_in = 32'h100;
        tick();
        check("drop grant", bus.mem_req_out, 1);
        bus.i_req_in = 1'b0;
        tick();
        check("drop still busy", bus.mem_req_out, 1);
        check("drop no stall", bus.i_stall_out, 0);
        bus.mem_ack_in = 1'b1; bus.mem_rdata_in = 32'h00112233;
        tick();
        pulses = bus.i_valid_out ? 1 : 0;
        check("drop rdata", bus.i_rdata_out, 32'h00112233);
        bus.mem_ack_in = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.i_valid_out) pulses++;
        end
        check("drop valid pulses", pulses, 1);
        check("drop end mem_req", bus.mem_req_out, 0);
        bus.i_addr_in = 32'h40;

        // ---------------- random traffic vs model ----------------
        drive_idle();
        rst = 1'b1;
        deaf = 1'b0; prev_req = 1'b0;
        model_step();
        tick();
        rst = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (!bus.i_req_in) begin
                if ($urandom_range(2) == 0) begin bus.i_req_in = 1'b1; bus.i_addr_in = $urandom; end
            end else if (bus.i_valid_out) begin
                if ($urandom_range(1) == 0) bus.i_req_in = 1'b0; else bus.i_addr_in = $urandom;
            end else if ($urandom_range(39) == 0) begin
                bus.i_req_in = 1'b0;
            end
            if (!bus.d_req_in || bus.d_valid_out) begin
                if (bus.d_valid_out && $urandom_range(1) == 0) bus.d_req_in = 1'b0;
                else if ($urandom_range(2) == 0 || bus.d_req_in) begin
                    bus.d_req_in   = 1'b1;
                    bus.d_we_in    = $urandom_range(1);
                    bus.d_be_in    = $urandom_range(15);
                    bus.d_addr_in  = $urandom;
                    bus.d_wdata_in = $urandom;
                end
            end else if ($urandom_range(39) == 0) begin
                bus.d_req_in = 1'b0;
            end
            if (bus.mem_req_out && !prev_req) deaf = ($urandom_range(5) == 0);
            prev_req = bus.mem_req_out;
            bus.mem_ack_in   = bus.mem_req_out ? (!deaf && $urandom_range(1) == 1)
                                               : ($urandom_range(3) == 0);
            bus.mem_rdata_in = $urandom;
            rst = ($urandom_range(249) == 0);

            model_step();
            tick();

            check("rnd mem_req", bus.mem_req_out, e_mreq);
            if (e_mreq) begin
                check("rnd mem_addr", bus.mem_addr_out, e_maddr);
                check("rnd mem_we", bus.mem_we_out, e_mwe);
                check("rnd mem_be", bus.mem_be_out, e_mbe);
                if (e_mwe) check("rnd mem_wdata", bus.mem_wdata_out, e_mwdata);
            end
            check("rnd i_valid", bus.i_valid_out, e_iv);
            check("rnd d_valid", bus.d_valid_out, e_dv);
            if (e_iv) begin
                check("rnd i_err", bus.i_err_out, e_ie);
                check("rnd i_rdata", bus.i_rdata_out, e_ird);
            end
            if (e_dv) begin
                check("rnd d_err", bus.d_err_out, e_de);
                check("rnd d_rdata", bus.d_rdata_out, e_drd);
            end
            check("rnd i_stall", bus.i_stall_out, bus.i_req_in & ~e_iv);
            check("rnd d_stall", bus.d_stall_out, bus.d_req_in & ~e_dv);
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch requester (I-port) and the load/store requester in the MEM stage (D-port).
- Grants one transaction at a time and registers the request onto a req/ack memory bus.
- Returns read data with a one-cycle valid pulse, and drives per-port stall lines back to the pipeline hazard logic.
- Includes a starvation guard for the I-port and a bus-timeout watchdog.

Parameters:
- WIDTH, 32, data and address width in bits.
- STARVE_MAX, 4, consecutive arbitrations the I-port may lose before it is forced to win.
- TIMEOUT, 16, maximum cycles in a busy state without mem_ack_in before abort. 0 disables the watchdog.

Ports:
- clk_in  in  1  clock; all state updates on the rising edge.
- rst_in  in  1  synchronous reset, active-high.
- i_req_in  in  1  I-port read request; level signal, held until i_valid_out.
- i_addr_in  in  WIDTH  I-port byte address.
- i_rdata_out  out  WIDTH  I-port read data; meaningful only while i_valid_out=1.
- i_valid_out  out  1  one-cycle completion pulse for the I-port.
- i_err_out  out  1  I-port timeout flag; valid together with i_valid_out.
- i_stall_out  out  1  i_req_in & ~i_valid_out (combinational).
- d_req_in  in  1  D-port request; level signal, held until d_valid_out.
- d_we_in  in  1  1 = write, 0 = read.
- d_be_in  in  WIDTH/8  byte enables for writes.
- d_addr_in  in  WIDTH  D-port byte address.
- d_wdata_in  in  WIDTH  D-port write data.
- d_rdata_out  out  WIDTH  D-port read data; 0 for writes.
- d_valid_out  out  1  one-cycle completion pulse for the D-port.
- d_err_out  out  1  D-port timeout flag.
- d_stall_out  out  1  d_req_in & ~d_valid_out (combinational).
- mem_req_out  out  1  bus request; held until ack or abort.
- mem_we_out  out  1  bus write enable.
- mem_be_out  out  WIDTH/8  bus byte enables; all ones for I-port reads.
- mem_addr_out  out  WIDTH  bus address.
- mem_wdata_out  out  WIDTH  bus write data.
- mem_rdata_in  in  WIDTH  bus read data; valid with mem_ack_in.
- mem_ack_in  in  1  bus completion, one cycle.

Behaviour:
- Reset:
  - State = IDLE; starve_cnt = 0; tmo_cnt = 0.
  - All registered outputs = 0.
  - Reset asserted mid-transaction aborts it: mem_req_out is 0 the cycle after reset is sampled, no valid pulse is generated, and mem_ack_in is ignored while in reset.
- FSM states: IDLE, BUSY_I, BUSY_D.
- Arbitration, in IDLE:
  - Only d_req_in: grant D.
  - Only i_req_in: grant I.
  - Both: grant D unless starve_cnt == STARVE_MAX, in which case grant I.
  - starve_cnt increments when I loses to D, and clears when I is granted.
- Grant:
  - At the edge where a grant is made, latch the winner's addr/we/be/wdata into the mem_*_out registers, set mem_req_out = 1, clear tmo_cnt, and move to BUSY_I or BUSY_D.
  - I-port grants drive mem_we_out = 0 and mem_be_out = all ones.
- Busy states:
  - mem_*_out are held stable while mem_req_out = 1.
  - tmo_cnt increments every cycle in which mem_ack_in = 0.
- Completion (mem_ack_in = 1 in BUSY_x):
  - Next cycle: x_valid_out = 1 for exactly one cycle, x_rdata_out = mem_rdata_in (0 for writes), x_err_out = 0, mem_req_out = 0.
  - The FSM returns to IDLE in the same edge.
- Timeout:
  - Applies when TIMEOUT != 0 and tmo_cnt == TIMEOUT-1 with no ack.
  - Next cycle: mem_req_out = 0, x_valid_out = 1, x_err_out = 1, x_rdata_out = 0, FSM to IDLE.
- Latency and throughput:
  - Request sampled in cycle N → mem_req_out high in N+1.
  - Ack in cycle N+k → valid in N+k+1.
  - Minimum is 2 cycles when the ack comes in N+1.
  - One IDLE cycle separates consecutive transactions; peak throughput is 1 transaction per 3 cycles.
- Boundary conditions:
  - Requester drops its req mid-transaction: the transaction still completes and valid still pulses. Ignoring the pulse is the requester's responsibility.
  - mem_ack_in while in IDLE: ignored, no output change.
  - Req held high through its valid-pulse cycle: that is not a new request. A new request is only arbitrated from IDLE in the following cycle.
  - Stall outputs are deasserted in the valid cycle, so the pipeline advances exactly once.

Test Plan:
- Reset then idle → all outputs 0, state IDLE. Assert rst_in during BUSY_D → mem_req_out 0 next cycle and no d_valid_out.
- I-read only, addr 0x40, ack 1 cycle after mem_req_out with rdata 0x00500093 → i_valid_out pulses once, 3 cycles after request, with i_rdata_out 0x00500093 and i_err_out 0.
- Simultaneous I and D requests, D write of 0xDEADBEEF, be 4'b0011, to 0x80 → D served first with mem_we_out 1 and mem_be_out 0011; I served next; d_rdata_out 0.
- D held continuously with back-to-back requests while I is also held, STARVE_MAX = 4 → I granted on the 5th arbitration, then starve_cnt = 0.
- TIMEOUT = 16, no ack → mem_req_out drops after 16 busy cycles; i_valid_out = 1 with i_err_out = 1 and i_rdata_out 0; FSM back to IDLE.
- Spurious mem_ack_in in IDLE, and i_req_in dropped mid-transaction → no state change for the spurious ack; the dropped transaction still completes and produces one valid pulse.
